// File: rtl/mem_resp_if.sv
// Request/response bus between the MMU master and the memory responder.
interface mem_resp_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [15:0] select_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        bad_sel_o;

  modport master (
    output ce_i, we_i, addr_i, data_i, select_i,
    input  data_o, ack_o, bad_sel_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, data_i, select_i,
    output data_o, ack_o, bad_sel_o
  );
endinterface

// File: rtl/mem_resp.sv
// Memory responder: routes MMU bus requests to an async SRAM (timed strobes)
// or a one-cycle-latency ROM, and answers each with a one-cycle ack pulse.
//
//   state   | meaning
//   IDLE    | waiting for ce_i; only state that samples a request
//   SRAM_RD | ce_n/oe_n low, wait counter running, capture on count 1
//   SRAM_WR | ce_n/we_n low, data driven, wait counter running
//   ROM_RD  | ROM address presented, capture ROM data on next edge
//   ACK     | one-cycle ack_o pulse; write data still driven for hold
//   RECOVER | all strobes idle, gives the master a cycle to update
module mem_resp #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_resp_if.slave         bus,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_data_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [9:0]        rom_addr_o,
  input  logic [31:0]       rom_data_i
);

  typedef enum logic [2:0] {IDLE, SRAM_RD, SRAM_WR, ROM_RD, ACK, RECOVER} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              bad_sel_q, bad_sel_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_data_q, sram_data_d;
  logic [9:0]        rom_addr_q, rom_addr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              data_oe_q, data_oe_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    rom_addr_d  = rom_addr_q;
    ack_d       = 1'b0;
    bad_sel_d   = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    data_oe_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ce_i) begin
          if (bus.select_i[0]) begin
            sram_addr_d = bus.addr_i[ADDR_W+1:2];
            cnt_d       = 4'(WAIT_CYCLES);
            ce_n_d      = 1'b0;
            if (bus.we_i) begin
              sram_data_d = bus.data_i;
              we_n_d      = 1'b0;
              data_oe_d   = 1'b1;
              state_d     = SRAM_WR;
            end else begin
              oe_n_d  = 1'b0;
              state_d = SRAM_RD;
            end
          end else if (bus.select_i[1] && !bus.we_i) begin
            rom_addr_d = bus.addr_i[11:2];
            state_d    = ROM_RD;
          end else begin
            // ROM writes are rejected without touching data_o; unmapped selects return zero
            if (!bus.select_i[1]) data_d = '0;
            ack_d     = 1'b1;
            bad_sel_d = 1'b1;
            state_d   = ACK;
          end
        end
      end
      SRAM_RD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d  = sram_data_i;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
        end
      end
      SRAM_WR: begin
        cnt_d     = cnt_q - 4'd1;
        data_oe_d = 1'b1;
        if (cnt_q == 4'd1) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          ce_n_d = 1'b0;
          we_n_d = 1'b0;
        end
      end
      ROM_RD: begin
        data_d  = rom_data_i;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK:     state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      bad_sel_q   <= 1'b0;
      data_q      <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      rom_addr_q  <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      bad_sel_q   <= bad_sel_d;
      data_q      <= data_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      rom_addr_q  <= rom_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign bus.data_o     = data_q;
  assign bus.ack_o      = ack_q;
  assign bus.bad_sel_o  = bad_sel_q;
  assign sram_addr_o    = sram_addr_q;
  assign sram_data_o    = sram_data_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;
  assign rom_addr_o     = rom_addr_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp with a small async SRAM model and a driven ROM word.
module tb_mem_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata, rom_data;
  logic        sram_doe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [9:0]  rom_addr;
  logic [31:0] sram_mem [16];

  int n_checks = 0;
  int n_errors = 0;

  int          r_lat, r_we_low, r_oe_low, r_doe_cnt, r_ovl;
  logic [31:0] r_data, r_sram_addr, r_sdata, r_rom_addr;
  logic        r_bad, r_doe, r_we_n, r_ce_n;

  mem_resp_if bus ();

  mem_resp #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .sram_addr_o    (sram_addr),
    .sram_data_o    (sram_wdata),
    .sram_data_i    (sram_rdata),
    .sram_data_oe_o (sram_doe),
    .sram_ce_n_o    (sram_ce_n),
    .sram_oe_n_o    (sram_oe_n),
    .sram_we_n_o    (sram_we_n),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_doe) sram_mem[sram_addr[3:0]] <= sram_wdata;

  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[3:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, drop ce_i after acceptance, record strobes until ack_o.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [15:0] sel);
    @(negedge clk);
    bus.ce_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.data_i = data; bus.select_i = sel;
    r_lat = 0; r_we_low = 0; r_oe_low = 0; r_doe_cnt = 0; r_ovl = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus.ce_i = 1'b0;
      if (!sram_we_n) r_we_low++;
      if (!sram_oe_n) r_oe_low++;
      if (sram_doe) r_doe_cnt++;
      if (sram_doe && !sram_oe_n) r_ovl++;
      if (bus.ack_o) begin
        r_lat = n; r_data = bus.data_o; r_bad = bus.bad_sel_o;
        r_sram_addr = 32'(sram_addr); r_sdata = sram_wdata; r_rom_addr = 32'(rom_addr);
        r_doe = sram_doe; r_we_n = sram_we_n; r_ce_n = sram_ce_n;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a1, a2;
    logic [31:0] d1, d2, ad1, ad2;
    logic seen;
    for (int i = 0; i < 16; i++) sram_mem[i] = 32'h0;
    rst = 1'b0;
    bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'h0; bus.data_i = 32'h0; bus.select_i = 16'h0;
    rom_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_bad", 32'(bus.bad_sel_o), 32'd0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_doe}, 32'hE);
    chk("rst_addrs", {2'd0, sram_addr, rom_addr}, 32'd0);
    chk("rst_sdata", sram_wdata, 32'd0);
    rst = 1'b1;

    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 16'h0001);
    chk("wr_lat", 32'(r_lat), 32'd3);
    chk("wr_we_low", 32'(r_we_low), 32'd2);
    chk("wr_oe_low", 32'(r_oe_low), 32'd0);
    chk("wr_addr", r_sram_addr, 32'h4);
    chk("wr_bad", 32'(r_bad), 32'd0);
    chk("wr_ack_hold", {29'd0, r_doe, r_we_n, r_ce_n}, 32'h7);
    chk("wr_sdata", r_sdata, 32'hDEADBEEF);
    chk("wr_data_o", r_data, 32'h0);
    chk("wr_doe_off", 32'(sram_doe), 32'd0);

    run_txn(1'b1, 32'h14, 32'hCAFEF00D, 16'h0001);
    chk("wr2_lat", 32'(r_lat), 32'd3);

    run_txn(1'b0, 32'h10, 32'h0, 16'h0001);
    chk("rd_lat", 32'(r_lat), 32'd3);
    chk("rd_data", r_data, 32'hDEADBEEF);
    chk("rd_oe_low", 32'(r_oe_low), 32'd2);
    chk("rd_doe", 32'(r_doe_cnt), 32'd0);
    chk("rd_overlap", 32'(r_ovl), 32'd0);
    chk("rd_bad", 32'(r_bad), 32'd0);

    rom_data = 32'h12345678;
    run_txn(1'b0, 32'h404, 32'h0, 16'h0002);
    chk("rom_addr", r_rom_addr, 32'h101);
    chk("rom_lat", 32'(r_lat), 32'd2);
    chk("rom_data", r_data, 32'h12345678);
    chk("rom_bad", 32'(r_bad), 32'd0);

    run_txn(1'b1, 32'h808, 32'h55, 16'h0002);
    chk("romwr_lat", 32'(r_lat), 32'd1);
    chk("romwr_bad", 32'(r_bad), 32'd1);
    chk("romwr_addr", r_rom_addr, 32'h101);
    chk("romwr_sram", 32'(r_we_low), 32'd0);

    run_txn(1'b0, 32'h20, 32'h0, 16'h0000);
    chk("unmap_lat", 32'(r_lat), 32'd1);
    chk("unmap_bad", 32'(r_bad), 32'd1);
    chk("unmap_data", r_data, 32'h0);

    run_txn(1'b0, 32'h14, 32'h0, 16'h0003);
    chk("prio_lat", 32'(r_lat), 32'd3);
    chk("prio_data", r_data, 32'hCAFEF00D);
    chk("prio_bad", 32'(r_bad), 32'd0);

    // ce_i held across two reads; addr_i changes while the first is in flight
    @(negedge clk);
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10; bus.select_i = 16'h0001;
    a1 = 0; a2 = 0; d1 = 0; d2 = 0; ad1 = 0; ad2 = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) bus.addr_i = 32'h14;
      if (bus.ack_o) begin
        if (a1 == 0) begin
          a1 = n; d1 = bus.data_o; ad1 = 32'(sram_addr);
        end else begin
          a2 = n; d2 = bus.data_o; ad2 = 32'(sram_addr);
          break;
        end
      end
    end
    bus.ce_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_lat1", 32'(a1), 32'd3);
    chk("b2b_addr1", ad1, 32'h4);
    chk("b2b_data1", d1, 32'hDEADBEEF);
    chk("b2b_gap", 32'(a2 - a1), 32'd5);
    chk("b2b_addr2", ad2, 32'h5);
    chk("b2b_data2", d2, 32'hCAFEF00D);

    // reset in the middle of a write, request still held afterwards
    @(negedge clk);
    bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h18; bus.data_i = 32'h0BADF00D;
    bus.select_i = 16'h0001;
    @(negedge clk);
    chk("rstwr_pre_we_n", 32'(sram_we_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rstwr_strobes", {29'd0, sram_we_n, sram_doe, sram_ce_n}, 32'h5);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack_o) seen = 1'b1;
    end
    chk("rstwr_no_ack", 32'(seen), 32'd0);
    rst = 1'b1;
    r_lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus.ce_i = 1'b0;
      if (bus.ack_o) begin
        r_lat = n;
        break;
      end
    end
    chk("rstwr_relat", 32'(r_lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 Parameter WAIT_CYCLES, default 2 (legal 1..15), SRAM strobe length in clocks.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-005 ce_i  in  1  request valid from MMU bus master (1 = enable).
REQ-006 we_i  in  1  1 = write, 0 = read.
REQ-007 addr_i  in  32  physical byte address; SRAM word address = addr_i[ADDR_W+1:2].
REQ-008 data_i  in  32  write data (always full word; partial writes are resolved by master read-modify-write).
REQ-009 select_i  in  16  device select; bit0 = SRAM, bit1 = ROM, others unmapped.
REQ-010 data_o  out  32  read data, valid while ack_o=1.
REQ-011 ack_o  out  1  registered one-cycle completion pulse.
REQ-012 bad_sel_o  out  1  one-cycle pulse, coincident with ack_o, for an unmapped or illegal access.
REQ-013 sram_addr_o  out  ADDR_W; sram_data_o  out  32; sram_data_i  in  32; sram_data_oe_o  out  1 (1 = drive bus).
REQ-014 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each, active-low strobes.
REQ-015 rom_addr_o  out  10  ROM word address = addr_i[11:2]; rom_data_i  in  32, valid one clock after rom_addr_o.

Function
REQ-016 States: IDLE, SRAM_RD, SRAM_WR, ROM_RD, ACK, RECOVER; encoding free.
REQ-017 Requests are sampled only in IDLE; ce_i in any other state is ignored.
REQ-018 Priority in IDLE with ce_i=1: select_i[0] -> SRAM; else select_i[1] -> ROM; else unmapped.
REQ-019 On acceptance, latch addr, data, and we into internal registers; outputs use latched values until next IDLE.
REQ-020 SRAM read: IDLE -> SRAM_RD, load wait counter = WAIT_CYCLES; ce_n=0, oe_n=0, we_n=1, data_oe=0 during SRAM_RD.
REQ-021 SRAM_RD: counter decrements each clock; on the edge where counter=1, capture sram_data_i into data_o and go to ACK.
REQ-022 SRAM write: IDLE -> SRAM_WR; ce_n=0, we_n=0, oe_n=1, data_oe=1 for WAIT_CYCLES clocks, then go to ACK.
REQ-023 In ACK after a write: we_n=1 and ce_n=1, with data_oe=1 and sram_data_o held for data hold time.
REQ-024 ROM read with we=0: IDLE -> ROM_RD for one clock; capture rom_data_i into data_o; go to ACK.
REQ-025 ROM write (select ROM, we=1): no ROM activity; go straight to ACK with bad_sel_o=1.
REQ-026 Unmapped select (including select_i=0): go straight to ACK with data_o=0 and bad_sel_o=1.
REQ-027 ACK lasts exactly one clock with ack_o=1; next state is RECOVER.
REQ-028 RECOVER lasts one clock with all strobes inactive and ack_o=0; next state is IDLE. The master uses this gap to update its request.
REQ-029 Latency, counted from the acceptance edge to the cycle ack_o=1:
  - SRAM read or write: WAIT_CYCLES+1 clocks.
  - ROM read: 2 clocks.
  - Unmapped access: 1 clock.
REQ-030 data_o holds its last captured value until the next capture; a write does not alter data_o.
REQ-031 sram_data_oe_o and sram_oe_n_o=0 are never both asserted in the same cycle.

Reset
REQ-032 While rst=0:
  - state = IDLE; ack_o=0; bad_sel_o=0; data_o=0.
  - sram_ce_n_o=1, sram_oe_n_o=1, sram_we_n_o=1, sram_data_oe_o=0.
  - sram_addr_o=0, sram_data_o=0, rom_addr_o=0.
REQ-033 Reset asserted mid-transaction aborts it without ack_o. A request held on ce_i after rst deasserts is accepted on the first subsequent edge.

Verification
REQ-034 WAIT_CYCLES=2; SRAM write addr 0x00000010, data 0xDEADBEEF, select 0x0001:
  - we_n low for 2 clocks, sram_addr_o=0x4.
  - ack_o pulses 3 clocks after acceptance.
  - bad_sel_o=0.
REQ-035 SRAM read of addr 0x00000010 after the REQ-034 write (SRAM model):
  - data_o=0xDEADBEEF with ack_o, 3 clocks after acceptance.
  - oe_n low for 2 clocks, data_oe=0 throughout.
REQ-036 ROM read addr 0x00000404, select 0x0002, rom_data_i=0x12345678:
  - rom_addr_o=0x101.
  - ack_o 2 clocks after acceptance, data_o=0x12345678.
REQ-037 Unmapped accesses:
  - select 0x0000 read -> ack_o and bad_sel_o next clock, data_o=0.
  - select 0x0002 with we=1 -> ack_o and bad_sel_o, ROM untouched.
REQ-038 Back-to-back and reset handling:
  - ce_i held high across two SRAM reads -> one RECOVER cycle between ack pulses; changes to addr_i during SRAM_RD have no effect on sram_addr_o.
  - rst=0 during SRAM_WR -> we_n=1 and data_oe=0 immediately, no ack_o.
